// File: rtl/pcie_us_cfg_mgmt_arb_if.sv
// Request/response and configuration-management signal bundle for pcie_us_cfg_mgmt_arb.
// slave is the arbiter's view; master is the requesters' plus PCIe core's view.
interface pcie_us_cfg_mgmt_arb_if #(
    parameter int PORTS = 2
);
    logic [PORTS-1:0]    s_req_valid;
    logic [PORTS-1:0]    s_req_ready;
    logic [PORTS-1:0]    s_req_write;
    logic [PORTS*10-1:0] s_req_addr;
    logic [PORTS*8-1:0]  s_req_function_number;
    logic [PORTS*32-1:0] s_req_write_data;
    logic [PORTS*4-1:0]  s_req_byte_enable;
    logic [PORTS-1:0]    s_rsp_valid;
    logic [31:0]         s_rsp_data;
    logic                s_rsp_error;

    logic [9:0]          cfg_mgmt_addr;
    logic [7:0]          cfg_mgmt_function_number;
    logic                cfg_mgmt_write;
    logic [31:0]         cfg_mgmt_write_data;
    logic [3:0]          cfg_mgmt_byte_enable;
    logic                cfg_mgmt_read;
    logic [31:0]         cfg_mgmt_read_data;
    logic                cfg_mgmt_read_write_done;

    // Handshake: a request is taken in the single cycle where s_req_valid and
    // s_req_ready are both high; s_rsp_valid is a one-cycle pulse with no backpressure.
    modport slave (
        input  s_req_valid, s_req_write, s_req_addr, s_req_function_number,
               s_req_write_data, s_req_byte_enable,
               cfg_mgmt_read_data, cfg_mgmt_read_write_done,
        output s_req_ready, s_rsp_valid, s_rsp_data, s_rsp_error,
               cfg_mgmt_addr, cfg_mgmt_function_number, cfg_mgmt_write,
               cfg_mgmt_write_data, cfg_mgmt_byte_enable, cfg_mgmt_read
    );

    modport master (
        output s_req_valid, s_req_write, s_req_addr, s_req_function_number,
               s_req_write_data, s_req_byte_enable,
               cfg_mgmt_read_data, cfg_mgmt_read_write_done,
        input  s_req_ready, s_rsp_valid, s_rsp_data, s_rsp_error,
               cfg_mgmt_addr, cfg_mgmt_function_number, cfg_mgmt_write,
               cfg_mgmt_write_data, cfg_mgmt_byte_enable, cfg_mgmt_read
    );
endinterface

// File: rtl/pcie_us_cfg_mgmt_arb.sv
// Round-robin arbiter sharing the PCIe core cfg_mgmt port between PORTS requesters.
// Optional done-wait timeout enabled by macro PCIE_US_CFG_MGMT_ARB_TIMEOUT_EN.
module pcie_us_cfg_mgmt_arb #(
    parameter int PORTS   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                         clk,
    input  logic                         rst_n,
    pcie_us_cfg_mgmt_arb_if.slave        bus,
    output logic [1:0]                   dbg_state
);
    localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    if (PORTS < 1 || PORTS > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
        $error("pcie_us_cfg_mgmt_arb: PORTS or TIMEOUT out of range");
    end

    logic [1:0]       state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    gnt_q;
    logic [PW-1:0]    gnt_idx;
    logic [PW-1:0]    ptr_next;
    logic             gnt_any;
    logic [PORTS-1:0] req_ready;
    logic [PORTS-1:0] rsp_valid;
    logic [31:0]      rsp_data;
    logic [9:0]       mgmt_addr;
    logic [7:0]       mgmt_fn;
    logic             mgmt_write;
    logic [31:0]      mgmt_wdata;
    logic [3:0]       mgmt_be;
    logic             mgmt_read;

    // Search from ptr upward first, then wrap to the ports below ptr.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int j = 0; j < PORTS; j++) begin
            if (!gnt_any && j >= int'(ptr) && bus.s_req_valid[j]) begin
                gnt_any = 1'b1;
                gnt_idx = PW'(j);
            end
        end
        for (int j = 0; j < PORTS; j++) begin
            if (!gnt_any && j < int'(ptr) && bus.s_req_valid[j]) begin
                gnt_any = 1'b1;
                gnt_idx = PW'(j);
            end
        end
    end

    always_comb begin
        ptr_next = (int'(gnt_idx) == PORTS - 1) ? '0 : gnt_idx + PW'(1);
    end

    // Ready is gated by rst_n so no accept pulse can appear while reset is held.
    always_comb begin
        req_ready = '0;
        if (rst_n && state == ST_IDLE && gnt_any) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

`ifdef PCIE_US_CFG_MGMT_ARB_TIMEOUT_EN
    logic [15:0] cnt;
    logic        rsp_error;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            gnt_q      <= '0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            mgmt_addr  <= '0;
            mgmt_fn    <= '0;
            mgmt_write <= 1'b0;
            mgmt_wdata <= '0;
            mgmt_be    <= '0;
            mgmt_read  <= 1'b0;
`ifdef PCIE_US_CFG_MGMT_ARB_TIMEOUT_EN
            cnt        <= '0;
            rsp_error  <= 1'b0;
`endif
        end else begin
            rsp_valid <= '0;
            case (state)
                ST_IDLE: begin
                    if (gnt_any) begin
                        gnt_q      <= gnt_idx;
                        ptr        <= ptr_next;
                        mgmt_addr  <= bus.s_req_addr[int'(gnt_idx)*10 +: 10];
                        mgmt_fn    <= bus.s_req_function_number[int'(gnt_idx)*8 +: 8];
                        mgmt_wdata <= bus.s_req_write_data[int'(gnt_idx)*32 +: 32];
                        mgmt_be    <= bus.s_req_byte_enable[int'(gnt_idx)*4 +: 4];
                        mgmt_write <= bus.s_req_write[gnt_idx];
                        mgmt_read  <= ~bus.s_req_write[gnt_idx];
`ifdef PCIE_US_CFG_MGMT_ARB_TIMEOUT_EN
                        cnt        <= 16'(TIMEOUT);
`endif
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Done takes priority over an expiring counter in the same cycle.
                    if (bus.cfg_mgmt_read_write_done) begin
                        rsp_data         <= mgmt_write ? 32'd0 : bus.cfg_mgmt_read_data;
                        rsp_valid[gnt_q] <= 1'b1;
                        mgmt_write       <= 1'b0;
                        mgmt_read        <= 1'b0;
`ifdef PCIE_US_CFG_MGMT_ARB_TIMEOUT_EN
                        rsp_error        <= 1'b0;
`endif
                        state            <= ST_RESP;
                    end
`ifdef PCIE_US_CFG_MGMT_ARB_TIMEOUT_EN
                    else if (cnt == 16'd1) begin
                        rsp_data         <= 32'd0;
                        rsp_error        <= 1'b1;
                        rsp_valid[gnt_q] <= 1'b1;
                        mgmt_write       <= 1'b0;
                        mgmt_read        <= 1'b0;
                        cnt              <= '0;
                        state            <= ST_RESP;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
`endif
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.s_req_ready              = req_ready;
    assign bus.s_rsp_valid              = rsp_valid;
    assign bus.s_rsp_data               = rsp_data;
`ifdef PCIE_US_CFG_MGMT_ARB_TIMEOUT_EN
    assign bus.s_rsp_error              = rsp_error;
`else
    assign bus.s_rsp_error              = 1'b0;
`endif
    assign bus.cfg_mgmt_addr            = mgmt_addr;
    assign bus.cfg_mgmt_function_number = mgmt_fn;
    assign bus.cfg_mgmt_write           = mgmt_write;
    assign bus.cfg_mgmt_write_data      = mgmt_wdata;
    assign bus.cfg_mgmt_byte_enable     = mgmt_be;
    assign bus.cfg_mgmt_read            = mgmt_read;
    assign dbg_state                    = state;

endmodule

// File: doc/pcie_us_cfg_mgmt_arb.md
PCIE_US_CFG_MGMT_ARB -- requirements
Module: pcie_us_cfg_mgmt_arb

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL have parameter PORTS, default 2, giving the number of requesters (range 1..8).
REQ-003 The block SHALL have parameter TIMEOUT, default 255, giving the done-wait limit in cycles (range 1..65535).
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 s_req_valid  in  PORTS  per-port request valid.
REQ-007 s_req_ready  out  PORTS  per-port one-cycle accept pulse.
REQ-008 s_req_write  in  PORTS  per-port op select: 1 write, 0 read.
REQ-009 s_req_addr  in  PORTS*10  per-port DWORD address.
REQ-010 s_req_function_number  in  PORTS*8  per-port target function.
REQ-011 s_req_write_data  in  PORTS*32  per-port write data.
REQ-012 s_req_byte_enable  in  PORTS*4  per-port byte enables.
REQ-013 s_rsp_valid  out  PORTS  per-port one-cycle response pulse.
REQ-014 s_rsp_data  out  32  read data, shared by all ports.
REQ-015 s_rsp_error  out  1  timeout flag, shared by all ports.
REQ-016 cfg_mgmt_addr, cfg_mgmt_function_number, cfg_mgmt_write, cfg_mgmt_write_data, cfg_mgmt_byte_enable, cfg_mgmt_read  out  10/8/1/32/4/1  to the PCIe core configuration management port.
REQ-017 cfg_mgmt_read_data  in  32  and cfg_mgmt_read_write_done  in  1  from the PCIe core.

Function
REQ-018 The block SHALL implement a three-state FSM: IDLE, ISSUE and RESP.
REQ-019 In IDLE, when any s_req_valid is high, the block SHALL grant round-robin, starting the search at the port after the last granted port; after reset, port 0 has highest priority.
REQ-020 The granted port's s_req_ready SHALL pulse for exactly one cycle (cycle N), and the block SHALL latch that port's fields in cycle N.
REQ-021 From cycle N+1, the block SHALL assert cfg_mgmt_write or cfg_mgmt_read (per s_req_write, never both) and enter ISSUE.
REQ-022 In ISSUE, all cfg_mgmt outputs SHALL be registered and held stable until cfg_mgmt_read_write_done is sampled high.
REQ-023 On the done cycle, the block SHALL capture cfg_mgmt_read_data, deassert the strobe on the next edge, and enter RESP.
REQ-024 In RESP, s_rsp_valid of the granted port SHALL pulse for exactly one cycle with s_rsp_data (0 for writes) and s_rsp_error; there is no response backpressure. The FSM then returns to IDLE.
REQ-025 Back-to-back throughput SHALL be at most one transaction per 4 cycles when done returns in 1 cycle.
REQ-026 The block SHALL ignore cfg_mgmt_read_write_done in IDLE and in RESP.
REQ-027 s_req_valid deasserted by a non-granted port SHALL have no effect; a granted request is never withdrawn.
REQ-028 s_rsp_data and s_rsp_error SHALL hold their last values outside RESP.

Reset
REQ-029 On rst_n low, the block SHALL asynchronously clear every output to 0, set FSM to IDLE, set round-robin pointer to port 0, and clear the timeout counter.
REQ-030 Reset mid-transaction SHALL drop the strobe immediately and deliver no response.

Configuration
REQ-031 With macro PCIE_US_CFG_MGMT_ARB_TIMEOUT_EN defined, the block SHALL load a 16-bit counter with TIMEOUT on ISSUE entry and decrement it each ISSUE cycle.
REQ-032 With the macro defined, if the counter reaches 0 without done, the block SHALL drop the strobe, go to RESP, and drive s_rsp_error=1 with s_rsp_data=0; done sampled in the same cycle as 0 SHALL win (success, error=0).
REQ-033 Without the macro, the counter logic SHALL be absent, ISSUE SHALL wait indefinitely, and s_rsp_error SHALL be tied to 0.

Verification
REQ-034 Port 0 read, addr 0x032, fn 0, done after 3 cycles with data 0x0000_2810 -> read high cycles N+1..N+4, s_rsp_valid[0] one cycle, data 0x0000_2810, error 0.
REQ-035 Ports 0 and 1 both valid continuously -> grants alternate 0,1,0,1; no port is granted twice consecutively.
REQ-036 Port 1 write, data 0xDEAD_BEEF, be 4'hF -> cfg_mgmt_write=1 with matching fields, read=0, s_rsp_data=0.
REQ-037 Macro defined, TIMEOUT=16, done never asserted -> strobe drops after 16 ISSUE cycles, s_rsp_error=1; done asserted on the final cycle -> error=0.
REQ-038 rst_n pulsed low during ISSUE -> all outputs 0 asynchronously, no s_rsp_valid, next grant to port 0.
